// File: rtl/sr_fetch_pkg.sv
// rtl/sr_fetch_pkg.sv - shared types and helpers for the instruction fetch front end
package sr_fetch_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sr_fetch_fifo.sv
// rtl/sr_fetch_fifo.sv - synchronous fetch-entry FIFO with flush
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sr_fetch_fifo import sr_fetch_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  entry_t                    wdata_i,
  output entry_t                    rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic   [AW:0]   wptr_q;
  logic   [AW:0]   rptr_q;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sr_fetch_unit.sv
// rtl/sr_fetch_unit.sv - decoupled instruction fetch: PC, credit and drop logic around the queue
// Define SR_FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module sr_fetch_unit import sr_fetch_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [XLEN-1:0]    inst_pc
);

  localparam int            CW     = cnt_w(DEPTH);
  localparam logic [CW:0]   CREDIT = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, fifo_count;
  logic [CW:0]     inflight;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic            gnt_acc, rsp_keep, bypass;
  logic            unused_bits;
  entry_t          head, wentry;

  assign inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
  assign imem_req  = ~rst & ~redirect & (inflight < CREDIT);
  assign imem_addr = fetch_pc_q >> 2;
  assign gnt_acc   = imem_req & imem_gnt;
  assign rsp_keep  = imem_rvalid & ~redirect & (drop_q == '0);

`ifdef SR_FETCH_BYPASS_EN
  assign bypass = rsp_keep & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push   = rsp_keep & ~(bypass & inst_ready);
  assign fifo_pop    = inst_ready & ~fifo_empty;
  assign wentry      = '{pc: resp_pc_q, instr: imem_rdata};
  assign unused_bits = ^{fifo_full, redirect_pc[1:0]};

  sr_fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .wdata_i (wentry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // An empty queue shows the PC of the next expected response.
  always_comb begin
    inst_valid = ~fifo_empty;
    inst_data  = head.instr;
    inst_pc    = head.pc;
    if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = imem_rdata;
      inst_pc    = resp_pc_q;
    end else if (fifo_empty) begin
      inst_data  = '0;
      inst_pc    = resp_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(gnt_acc) - CW'(imem_rvalid);
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = outst_d;
    end else begin
      if (gnt_acc)                      fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rvalid && drop_q != '0)  drop_d     = drop_q - CW'(1);
      if (rsp_keep)                     resp_pc_d  = resp_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_sr_fetch_unit.sv
// tb/tb_sr_fetch_unit.sv - randomized self-checking bench for sr_fetch_unit
module tb_sr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  sr_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        memq[$];
  int          checks = 0, errors = 0, cyc = 0, last_due = 0;
  int          p_gnt = 100, p_rdy = 100, p_redir_pm = 0, lat_min = 1, lat_max = 1;
  logic [31:0] exp_pc, exp_req_pc;
  int          exp_drop, hs_cnt, gr_cnt, first_gnt_cyc, first_valid_cyc, rel_cyc;
  bit          post_redir, last_dr;

  function automatic logic [31:0] memfn(input logic [31:0] w);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    inst_ready = 1'b0; imem_rdata = '0; redirect_pc = '0;
    memq.delete(); last_due = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    rst = 1'b0;
    exp_pc = '0; exp_req_pc = '0; post_redir = 1'b0;
    hs_cnt = 0; gr_cnt = 0; first_gnt_cyc = -1; first_valid_cyc = -1; rel_cyc = cyc;
  endtask

  // mode 0: random redirect, 1: forced redirect to rpc, 2: redirect only when a response and a valid head coincide
  task automatic step(input int mode, input logic [31:0] rpc);
    bit rv, hs, gr, dr;
    int lat, due;
    rv = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? memfn(memq[0].addr) : $urandom;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    inst_ready  = ($urandom_range(99) < p_rdy);
    redirect    = 1'b0;
    redirect_pc = $urandom;
    #1;
    dr = (mode == 1) || (mode == 2 && rv && inst_valid) ||
         (mode == 0 && $urandom_range(999) < p_redir_pm);
    if (dr) begin
      redirect = 1'b1;
      if (mode != 0) redirect_pc = rpc;
      #1;
    end
    if (post_redir) begin
      chk("post_redir_valid", inst_valid, 0);
      chk("post_redir_addr", imem_addr, {2'b00, exp_req_pc[31:2]});
      if (!dr) chk("post_redir_req", imem_req, memq.size() < DEPTH);
    end
    if (dr) chk("redir_req_low", imem_req, 0);
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    hs = inst_valid && inst_ready;
    if (hs) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, memfn({2'b00, exp_pc[31:2]}));
      exp_pc += 32'd4;
      hs_cnt++;
    end
    if (dut.u_fifo.push_i) chk("no_push_full", dut.u_fifo.full_o, 0);
    gr = imem_req && imem_gnt;
    if (rv) void'(memq.pop_front());
    if (gr) begin
      chk("req_addr", imem_addr, {2'b00, exp_req_pc[31:2]});
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due < last_due) due = last_due;
      last_due = due;
      memq.push_back('{addr: imem_addr, due: due});
      chk("inflight_cap", memq.size() <= DEPTH, 1);
      exp_req_pc += 32'd4;
      gr_cnt++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    if (dr) begin
      exp_pc     = {redirect_pc[31:2], 2'b00};
      exp_req_pc = {redirect_pc[31:2], 2'b00};
      exp_drop   = memq.size();
    end
    post_redir = dr;
    last_dr    = dr;
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);

    // zero-wait memory, decode always ready
    do_reset();
    p_gnt = 100; p_rdy = 100; lat_min = 1; lat_max = 1; p_redir_pm = 0;
    repeat (24) step(0, '0);
    chk("first_req_cycle", first_gnt_cyc, rel_cyc);
`ifdef SR_FETCH_BYPASS_EN
    chk("first_valid_lat", first_valid_cyc - first_gnt_cyc, 1);
    chk("zero_wait_throughput", hs_cnt, 23);
    chk("bypass_count", dut.u_fifo.count_o, 0);
`else
    chk("first_valid_lat", first_valid_cyc - first_gnt_cyc, 2);
    chk("zero_wait_throughput", hs_cnt, 22);
`endif

    // decode stalled: credits cap the fetches at DEPTH
    do_reset();
    p_rdy = 0;
    repeat (10) step(0, '0);
    chk("stall_grants", gr_cnt, DEPTH);
    chk("stall_req_low", imem_req, 0);
    chk("stall_next_addr", imem_addr, 32'h4);
    p_rdy = 100;
    repeat (12) step(0, '0);
    chk("stall_drain", hs_cnt >= 8, 1);

    // 3-cycle latency, redirect with requests in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && memq.size() < 2; i++) step(0, '0);
    chk("inflight_before_redir", memq.size() >= 2, 1);
    step(1, 32'h100);
    chk("drop_after_redir", dut.drop_q, exp_drop);
    repeat (14) step(0, '0);
    chk("redir_progress", exp_pc > 32'h100, 1);

    // redirect coinciding with a response and a pop
    do_reset();
    p_rdy = 50;
    last_dr = 1'b0;
    for (int i = 0; i < 40 && !last_dr; i++) step(2, 32'h240);
    chk("redir_trigger", last_dr, 1);
    chk("drop_rvalid_pop", dut.drop_q, exp_drop);
    p_rdy = 100;
    repeat (12) step(0, '0);
    chk("redir_pop_progress", exp_pc > 32'h240, 1);

    // PC wrap at the top of the address space
    lat_min = 1; lat_max = 1;
    step(1, 32'hFFFF_FFFC);
    repeat (8) step(0, '0);
    chk("wrap_progress", (exp_pc >= 32'h4) && (exp_pc <= 32'h20), 1);

    // randomized traffic with occasional redirects and one mid-run reset
    p_gnt = 70; p_rdy = 60; lat_min = 1; lat_max = 4; p_redir_pm = 20;
    repeat (1500) step(0, '0);
    do_reset();
    repeat (1500) step(0, '0);
    chk("random_progress", hs_cnt > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
